// File: rtl/mp_pkg.sv
// Shared definitions for the Fibonacci microprocessor and its program loader.
package mp_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/instr_mem_loader.sv
// Program loader: packs a byte stream little-endian into instruction words,
// writes them to consecutive word addresses and holds the core in reset
// until the requested number of words is in memory.
module instr_mem_loader #(
  parameter int DATA_WIDTH = mp_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mp_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done
);

  import mp_pkg::*;

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [ADDR_WIDTH:0] MAX_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [BIW-1:0]      LAST_BYTE = BIW'(BYTES - 1);

  loader_state_t state, state_next;

  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [BIW-1:0]        byte_idx;
  logic [DATA_WIDTH-1:0] word_buf;
  logic                  last_word;

  // The word being written is the final one of the program.
  assign last_word = ({1'b0, word_idx} == (len - 1'b1));

  // State register; reset abandons any partial word and returns to IDLE.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: start only counts in IDLE/DONE, a zero length goes straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (prog_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (byte_valid && (byte_idx == LAST_BYTE)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = last_word ? DONE : LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Length latch, word/byte counters and the little-endian packing buffer.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_buf <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len      <= (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        LOAD: begin
          if (byte_valid) begin
            for (int i = 0; i < BYTES; i++) begin
              if (byte_idx == BIW'(i)) begin
                word_buf[8*i +: 8] <= byte_data;
              end
            end
            byte_idx <= byte_idx + 1'b1;
          end
        end
        WRITE: begin
          if (!last_word) begin
            word_idx <= word_idx + 1'b1;
            byte_idx <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs come only from registers so no input reaches an output combinationally.
  always_comb begin
    byte_ready = (state == LOAD);
    mem_we     = (state == WRITE);
    mem_addr   = word_idx;
    mem_wdata  = word_buf;
    core_rst_n = (state == DONE);
    busy       = (state == LOAD) || (state == WRITE);
    done       = (state == DONE);
  end

endmodule
